// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, state encoding and round-robin pick for mux_arb_4
package mux_arb_pkg;

  localparam int NUM_REQ          = 4;
  localparam int SEL_W            = 2;
  localparam int CNT_W            = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of req in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // Walking the offsets downward lets the smallest offset overwrite the result last.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   ptr);
    pick_t            p;
    logic [SEL_W-1:0] cand;
    p = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_arb_4_mux.sv
// rtl/mux_arb_4_mux.sv - gate-level 4:1 single-bit data multiplexer
import mux_arb_pkg::*;

module mux_arb_4_mux (
  input  logic [NUM_REQ-1:0] d,
  input  logic [SEL_W-1:0]   sel,
  output logic               o
);

  logic sel0_n;
  logic sel1_n;
  logic t0;
  logic t1;
  logic t2;
  logic t3;

  not g_n0 (sel0_n, sel[0]);
  not g_n1 (sel1_n, sel[1]);

  and g_a0 (t0, d[0], sel1_n, sel0_n);
  and g_a1 (t1, d[1], sel1_n, sel[0]);
  and g_a2 (t2, d[2], sel[1], sel0_n);
  and g_a3 (t3, d[3], sel[1], sel[0]);

  or  g_o  (o, t0, t1, t2, t3);

endmodule

// File: rtl/mux_arb_4.sv
// rtl/mux_arb_4.sv - 4-way round-robin arbiter with hold timeout driving a shared 1-bit output
import mux_arb_pkg::*;

module mux_arb_4 #(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] i,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   s,
  output logic               y,
  output logic               busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state;
  state_t             state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [SEL_W-1:0]   s_n;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   ptr_n;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   hold_n;
  logic               take;
  pick_t              pick;
  logic               mux_y;

  // Arbitration state; reset drops any grant immediately, without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      s        <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      s        <= s_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  // Next grant: the holder is masked out so it can never win its own rotation,
  // and release is tested first so release+timeout behaves as plain release.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    s_n     = s;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    take    = 1'b0;
    pick    = rr_pick(req & ~gnt, ptr);

    case (state)
      IDLE: begin
        take = pick.found;
      end
      GRANT: begin
        if (!req[s]) begin
          if (pick.found) begin
            take = 1'b1;
          end else begin
            gnt_n   = '0;
            state_n = IDLE;
          end
        end else if (hold_cnt == HOLD_LAST && pick.found) begin
          take = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    if (take) begin
      state_n = GRANT;
      gnt_n   = NUM_REQ'(1) << pick.idx;
      s_n     = pick.idx;
      ptr_n   = pick.idx + SEL_W'(1);
      hold_n  = '0;
    end
  end

  mux_arb_4_mux u_mux (
    .d   (i),
    .sel (s),
    .o   (mux_y)
  );

  assign busy = |gnt;
  assign y    = mux_y & busy;

endmodule

// File: tb/tb_mux_arb_4.sv
// tb/tb_mux_arb_4.sv - scoreboard bench for mux_arb_4 with directed vectors
module tb_mux_arb_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] i = '0;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       y;
  logic       busy;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] s;
    logic       busy;
    logic       y;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  mux_arb_4 #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .i     (i),
    .gnt   (gnt),
    .s     (s),
    .y     (y),
    .busy  (busy)
  );

  function automatic obs_t observe();
    obs_t o;
    o.gnt  = gnt;
    o.s    = s;
    o.busy = busy;
    o.y    = y;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b s=%0d busy=%b y=%b, want gnt=%b s=%0d busy=%b y=%b",
               name, got.gnt, got.s, got.busy, got.y, want.gnt, want.s, want.busy, want.y);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] eg,
                      input logic [1:0] es, input string name);
    obs_t e;
    req    = r;
    i      = d;
    e.gnt  = eg;
    e.s    = es;
    e.busy = |eg;
    e.y    = (|eg) ? d[es] : 1'b0;
    exp_q.push_back(e);
    tag_q.push_back(name);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: one-hot every cycle, and compare against the scoreboard when an entry is due.
  initial begin
    obs_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      n_checks++;
      if ($countones(gnt) > 1) begin
        n_fail++;
        $display("FAIL onehot: got gnt=%b, want at most one bit set", gnt);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, observe(), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] one;
    int         g;
    one = 4'b0001;

    // Asynchronous reset state
    #1 rst_n = 1'b0;
    #1 check("reset_state", observe(), obs_t'(8'h00));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // First grant, then hand-over with no idle cycle, then release to idle
    step(4'b0101, 4'b0000, 4'b0001, 2'd0, "first_grant_0");
    step(4'b0100, 4'b0000, 4'b0100, 2'd2, "handover_2");
    step(4'b0000, 4'b0100, 4'b0000, 2'd2, "release_idle");
    step(4'b0000, 4'b0100, 4'b0000, 2'd2, "idle_keeps_s");

    // All requesting: 8-cycle grants rotating 0,1,2,3,0
    do_reset();
    for (int c = 0; c < 40; c++) begin
      g = (c / 8) % 4;
      step(4'b1111, 4'b0110, one << g, 2'(g), $sformatf("rotate_c%0d", c));
    end

    // Holder 0 drops exactly when its hold count reaches MAX_HOLD-1
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(4'b1001, 4'b0001, 4'b0001, 2'd0, $sformatf("hold0_c%0d", c));
    end
    step(4'b1000, 4'b1000, 4'b1000, 2'd3, "release_at_timeout");

    // Lone requester keeps the grant with no timeout; y follows i[1]
    step(4'b0010, 4'b0010, 4'b0010, 2'd1, "lone_takeover");
    for (int c = 0; c < 40; c++) begin
      step(4'b0010, (c < 20) ? 4'b0010 : 4'b0000, 4'b0010, 2'd1, $sformatf("lone_c%0d", c));
    end
    i = 4'b0010;
    #1 check("y_same_cycle_hi", observe(), obs_t'({4'b0010, 2'd1, 1'b1, 1'b1}));
    i = 4'b0000;
    #1 check("y_same_cycle_lo", observe(), obs_t'({4'b0010, 2'd1, 1'b1, 1'b0}));
    step(4'b0000, 4'b0010, 4'b0000, 2'd1, "lone_release");

    // Reset asserted mid-grant between edges
    step(4'b0100, 4'b0000, 4'b0100, 2'd2, "grant_2");
    i = 4'b0100;
    #1 check("pre_reset_y", observe(), obs_t'({4'b0100, 2'd2, 1'b1, 1'b1}));
    req   = 4'b1100;
    rst_n = 1'b0;
    #1 check("async_reset_drop", observe(), obs_t'(8'h00));
    @(posedge clk);
    #2 check("reset_no_restore", observe(), obs_t'(8'h00));
    rst_n = 1'b1;
    step(4'b1100, 4'b0100, 4'b0100, 2'd2, "post_reset_first");
    step(4'b0000, 4'b0000, 4'b0000, 2'd2, "final_idle");

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
